// File: rtl/service_4_led_challenger.sv
// service_4_led_challenger: one-hot LED challenge rounds for the Service 4 alarm mini-game.
// Each round shows a target, waits for cleared switches, then judges a stable match against a timeout.
module service_4_led_challenger #(
    parameter int          NLED           = 10,
    parameter int          TIMEOUT_CYCLES = 100,
    parameter int          HOLD_CYCLES    = 3,
    parameter logic [15:0] SEED           = 16'hACE1,
    parameter logic [2:0]  GAME_CODE      = 3'b010
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [2:0]      alarm_state,
    input  logic [NLED-1:0] SPDTs,
    output logic [NLED-1:0] random_led,
    output logic            round_pass,
    output logic            round_fail,
    output logic [15:0]     pass_count,
    output logic [15:0]     fail_count
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
    typedef enum logic [2:0] {IDLE, PICK, WAIT_CLR, ARMED, GAP} state_t;
    state_t          state, state_d;
    logic [15:0]     lfsr;
    logic [3:0]      prev_idx, prev_d, raw, cand;
    logic [TW-1:0]   timer, timer_d;
    logic [HW-1:0]   hold, hold_d;
    logic [NLED-1:0] led_d;
    logic [15:0]     pc_d, fc_d;
    logic            pass_d, fail_d, game, match, timeout, hold_done;
    assign game      = alarm_state == GAME_CODE;
    assign match     = SPDTs == random_led;
    assign timeout   = timer == TW'(TIMEOUT_CYCLES - 1);
    assign hold_done = match && hold == HW'(HOLD_CYCLES - 1);
    assign raw       = (lfsr[3:0] >= 4'(NLED)) ? lfsr[3:0] - 4'(NLED) : lfsr[3:0];
    // Bump a repeated index to its neighbour so consecutive targets always differ
    assign cand      = (raw != prev_idx) ? raw : (prev_idx == 4'(NLED - 1)) ? 4'd0 : prev_idx + 4'd1;
    always_comb begin
        state_d = state;
        led_d   = random_led;
        prev_d  = prev_idx;
        timer_d = timer;
        hold_d  = hold;
        pass_d  = 1'b0;
        fail_d  = 1'b0;
        pc_d    = pass_count;
        fc_d    = fail_count;
        if (!game) begin
            state_d = IDLE;
            led_d   = '0;
            pc_d    = '0;
            fc_d    = '0;
        end else begin
            case (state)
                IDLE: state_d = PICK;
                PICK: begin
                    state_d = WAIT_CLR;
                    led_d   = NLED'(1) << cand;
                    prev_d  = cand;
                    timer_d = '0;
                    hold_d  = '0;
                end
                WAIT_CLR, ARMED: begin
                    timer_d = timer + 1'b1;
                    if (state == ARMED) hold_d = match ? hold + 1'b1 : '0;
                    if (state == WAIT_CLR && SPDTs == '0) state_d = ARMED;
                    // A completed hold beats a coincident timeout
                    if (state == ARMED && hold_done) begin
                        state_d = GAP;
                        led_d   = '0;
                        pass_d  = 1'b1;
                        pc_d    = (&pass_count) ? pass_count : pass_count + 16'd1;
                    end else if (timeout) begin
                        state_d = GAP;
                        led_d   = '0;
                        fail_d  = 1'b1;
                        fc_d    = (&fail_count) ? fail_count : fail_count + 16'd1;
                    end
                end
                GAP:     state_d = PICK;
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            lfsr       <= SEED_EFF;
            prev_idx   <= '0;
            timer      <= '0;
            hold       <= '0;
            random_led <= '0;
            round_pass <= 1'b0;
            round_fail <= 1'b0;
            pass_count <= '0;
            fail_count <= '0;
        end else begin
            state      <= state_d;
            lfsr       <= lfsr[0] ? (lfsr >> 1) ^ 16'hB400 : lfsr >> 1;
            prev_idx   <= prev_d;
            timer      <= timer_d;
            hold       <= hold_d;
            random_led <= led_d;
            round_pass <= pass_d;
            round_fail <= fail_d;
            pass_count <= pc_d;
            fail_count <= fc_d;
        end
    end
endmodule

// File: tb/tb_service_4_led_challenger.sv
// tb_service_4_led_challenger: round table plus corner sequences for the LED challenger,
// with expected pulses queued at drive time and matched when the DUT pulses.
module tb_service_4_led_challenger;
    localparam logic [2:0] GAME = 3'b010;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [2:0]  alarm_state = 3'b000;
    logic [9:0]  SPDTs = 10'h000;
    logic [9:0]  random_led;
    logic        round_pass, round_fail;
    logic [15:0] pass_count, fail_count;
    int          total = 0, bad = 0, cyc = 0, pick_cyc = 0;
    logic [15:0] lfsr_m;
    logic [3:0]  prev_m = 4'd0;
    logic [9:0]  tgt = 10'h000, prev_tgt = 10'h000;
    logic [15:0] exp_pc = 16'd0, exp_fc = 16'd0;
    typedef struct { bit is_pass; int at; logic [15:0] pc; logic [15:0] fc; } ev_t;
    typedef struct { string name; int pre; logic [31:0] pat; int rel; bit pass; } rnd_t;
    ev_t  evq[$];
    ev_t  ev;
    rnd_t rounds[8];

    service_4_led_challenger #(.TIMEOUT_CYCLES(20), .HOLD_CYCLES(3)) dut (
        .clk(clk), .resetn(resetn), .alarm_state(alarm_state), .SPDTs(SPDTs),
        .random_led(random_led), .round_pass(round_pass), .round_fail(round_fail),
        .pass_count(pass_count), .fail_count(fail_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // Reference Galois LFSR, mask 16'hB400, reset to the default seed
    always @(posedge clk or negedge resetn)
        if (!resetn) lfsr_m <= 16'hACE1;
        else lfsr_m <= lfsr_m[0] ? (lfsr_m >> 1) ^ 16'hB400 : lfsr_m >> 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pick();
        logic [3:0] c;
        c = lfsr_m[3:0];
        if (c >= 4'd10) c = c - 4'd10;
        if (c == prev_m) c = (prev_m == 4'd9) ? 4'd0 : prev_m + 4'd1;
        prev_tgt = tgt;
        tgt = 10'd1 << c;
        prev_m = c;
        pick_cyc = cyc;
    endtask

    // Called in the PICK cycle; leaves the bench in the following PICK cycle.
    task automatic run_round(input rnd_t r);
        pick();
        if (r.pass) exp_pc = exp_pc + 16'd1;
        else exp_fc = exp_fc + 16'd1;
        evq.push_back('{r.pass, pick_cyc + r.rel, exp_pc, exp_fc});
        for (int i = 0; i < r.rel; i++) begin
            SPDTs = (i <= r.pre) ? 10'h3FF : (i == r.pre + 1) ? 10'h000 :
                    r.pat[i - r.pre - 2] ? tgt : ~tgt;
            step();
            if (i == 0) begin
                check({r.name, "_target"}, 32'(random_led), 32'(tgt));
                if (prev_tgt != 10'h000) check({r.name, "_target_changed"}, 32'(random_led != prev_tgt), 32'd1);
            end
        end
        check({r.name, "_gap_blank"}, 32'(random_led), 32'd0);
        SPDTs = 10'h000;
        step();
    endtask

    always @(negedge clk) begin
        if (resetn) begin
            check("onehot0", 32'($onehot0(random_led)), 32'd1);
            check("pulse_exclusive", 32'(round_pass & round_fail), 32'd0);
            if (round_pass || round_fail) begin
                if (evq.size() == 0) check("unexpected_pulse", 32'(round_pass | round_fail), 32'd0);
                else begin
                    ev = evq.pop_front();
                    check("pulse_kind", 32'(round_pass), 32'(ev.is_pass));
                    check("pulse_cycle", cyc, ev.at);
                    check("pass_count", 32'(pass_count), 32'(ev.pc));
                    check("fail_count", 32'(fail_count), 32'(ev.fc));
                end
            end
        end
    end

    initial begin
        rounds[0] = '{"basic_pass",    0,  32'h0000_0007, 5,  1'b1};
        rounds[1] = '{"never_clear",   30, 32'h0000_0000, 21, 1'b0};
        rounds[2] = '{"broken_hold",   0,  32'h0000_003B, 8,  1'b1};
        rounds[3] = '{"pass_at_limit", 0,  32'h0007_0000, 21, 1'b1};
        rounds[4] = '{"one_too_late",  0,  32'h0006_0000, 21, 1'b0};
        rounds[5] = '{"late_clear",    3,  32'h0000_0007, 8,  1'b1};
        rounds[6] = '{"flicker",       0,  32'h5555_5555, 21, 1'b0};
        rounds[7] = '{"clear_at_lim",  19, 32'hFFFF_FFFF, 21, 1'b0};
        #23 resetn = 1'b1;
        repeat (50) step();
        check("idle_led", 32'(random_led), 32'd0);
        check("idle_pass_count", 32'(pass_count), 32'd0);
        check("idle_fail_count", 32'(fail_count), 32'd0);
        check("idle_pulses", 32'({round_pass, round_fail}), 32'd0);
        alarm_state = GAME;
        step();
        check("pick_led_blank", 32'(random_led), 32'd0);
        for (int r = 0; r < 8; r++) run_round(rounds[r]);
        // Abort on the very edge that would have completed the hold
        pick();
        SPDTs = 10'h000;
        step();
        check("abort_target", 32'(random_led), 32'(tgt));
        step();
        SPDTs = tgt;
        step();
        step();
        alarm_state = 3'b100;
        step();
        check("abort_led", 32'(random_led), 32'd0);
        check("abort_pass_count", 32'(pass_count), 32'd0);
        check("abort_fail_count", 32'(fail_count), 32'd0);
        check("abort_pulses", 32'({round_pass, round_fail}), 32'd0);
        SPDTs = 10'h000;
        repeat (3) step();
        check("abort_idle_led", 32'(random_led), 32'd0);
        exp_pc = 16'd0;
        exp_fc = 16'd0;
        alarm_state = GAME;
        step();
        run_round(rounds[0]);
        pick();
        step();
        check("pre_reset_target", 32'(random_led), 32'(tgt));
        #2 resetn = 1'b0;
        #1;
        check("async_led", 32'(random_led), 32'd0);
        check("async_pass_count", 32'(pass_count), 32'd0);
        check("async_fail_count", 32'(fail_count), 32'd0);
        evq.delete();
        prev_m = 4'd0;
        tgt = 10'h000;
        exp_pc = 16'd0;
        exp_fc = 16'd0;
        step();
        step();
        #2 resetn = 1'b1;
        step();
        run_round(rounds[0]);
        repeat (2) step();
        check("queue_drained", 32'(evq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
